// File: rtl/rv_fetch_pkg.sv
// Types and constants shared by the instruction-fetch stage.
package rv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misaligned;
  } fetch_entry_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface if_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count; storage is not reset.
module fetch_fifo
  import rv_fetch_pkg::clog2;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CW = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~flush & (cnt != CW'(DEPTH));
  assign pop_ok  = pop & ~flush & (cnt != '0);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues in-order memory requests under a credit limit,
// pairs returned words with their PCs and queues them for decode; flush discards all.
module if_fetch_unit
  import rv_fetch_pkg::fetch_entry_t, rv_fetch_pkg::clog2;
#(
  parameter int              DEPTH     = 2,
  parameter int              XLEN      = rv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             pc_valid_i,
  output logic             pc_ready_o,
  input  logic             flush_i,
  if_fetch_unit_if.master  imem,
  output logic             instr_valid_o,
  output logic [XLEN-1:0]  instr_o,
  output logic [XLEN-1:0]  instr_pc_o,
  output logic             instr_misaligned_o,
  input  logic             instr_ready_i
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   q_cnt;
  logic [CW-1:0]   discard_cnt;
  logic [XLEN-1:0] tag_head;
  logic            aligned;
  logic            space;
  logic            grant;
  logic            mis_accept;
  logic            rsp_accept;
  logic            q_push;
  logic            q_pop;
  fetch_entry_t    q_push_data;
  fetch_entry_t    q_head;

  // Credit covers requests in flight plus queued words, so every response has a slot.
  assign aligned    = (pc_i[1:0] == 2'b00);
  assign space      = ({1'b0, out_cnt} + {1'b0, q_cnt}) < SW'(DEPTH);
  assign grant      = imem.imem_req_o & imem.imem_gnt_i;
  assign mis_accept = pc_valid_i & ~aligned & (out_cnt == '0) & (discard_cnt == '0)
                    & space & ~flush_i;
  assign rsp_accept = imem.imem_rvalid_i & (discard_cnt == '0) & ~flush_i;

  assign imem.imem_req_o  = pc_valid_i & aligned & space & ~flush_i;
  assign imem.imem_addr_o = pc_i;
  assign pc_ready_o       = grant | mis_accept;

  always_comb begin
    q_push      = 1'b0;
    q_push_data = '0;
    if (rsp_accept) begin
      q_push            = 1'b1;
      q_push_data.instr = imem.imem_rdata_i;
      q_push_data.pc    = tag_head;
    end else if (mis_accept) begin
      q_push                 = 1'b1;
      q_push_data.instr      = NOP_INSTR;
      q_push_data.pc         = pc_i;
      q_push_data.misaligned = 1'b1;
    end
  end

  assign q_pop = instr_valid_o & instr_ready_i;

  // The tag FIFO occupancy is the outstanding-request count.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (pc_i),
    .pop       (rsp_accept),
    .flush     (flush_i),
    .head      (tag_head),
    .count     (out_cnt)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (flush_i),
    .head      (q_head),
    .count     (q_cnt)
  );

  // Requests abandoned by a flush still return; their responses are swallowed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_cnt <= '0;
    end else if (flush_i) begin
      discard_cnt <= discard_cnt + out_cnt - CW'(imem.imem_rvalid_i);
    end else if (imem.imem_rvalid_i && (discard_cnt != '0)) begin
      discard_cnt <= discard_cnt - CW'(1);
    end
  end

  // Queue storage is unreset, so fields are forced to zero while the queue is empty.
  assign instr_valid_o      = (q_cnt != '0);
  assign instr_o            = instr_valid_o ? q_head.instr      : '0;
  assign instr_pc_o         = instr_valid_o ? q_head.pc         : '0;
  assign instr_misaligned_o = instr_valid_o ? q_head.misaligned : 1'b0;

`ifndef SYNTHESIS
  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem.imem_rvalid_i |-> ((out_cnt != '0) || (discard_cnt != '0)));
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a DEPTH=2 unit driven from a vector table and a
// DEPTH=4 unit with a one-cycle memory model for back-to-back streaming.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        pv_a, flush_a, rdy_a, prdy_a, vld_a, mis_a;
  logic [31:0] pc_a, instr_a, ipc_a;
  if_fetch_unit_if #(.XLEN(32)) bus_a ();

  if_fetch_unit #(.DEPTH(2)) dut_a (
    .clk (clk), .rst (rst), .pc_i (pc_a), .pc_valid_i (pv_a), .pc_ready_o (prdy_a),
    .flush_i (flush_a), .imem (bus_a), .instr_valid_o (vld_a), .instr_o (instr_a),
    .instr_pc_o (ipc_a), .instr_misaligned_o (mis_a), .instr_ready_i (rdy_a)
  );

  logic        pv_b, flush_b, rdy_b, prdy_b, vld_b, mis_b;
  logic [31:0] pc_b, instr_b, ipc_b;
  if_fetch_unit_if #(.XLEN(32)) bus_b ();

  if_fetch_unit #(.DEPTH(4)) dut_b (
    .clk (clk), .rst (rst), .pc_i (pc_b), .pc_valid_i (pv_b), .pc_ready_o (prdy_b),
    .flush_i (flush_b), .imem (bus_b), .instr_valid_o (vld_b), .instr_o (instr_b),
    .instr_pc_o (ipc_b), .instr_misaligned_o (mis_b), .instr_ready_i (rdy_b)
  );

  // One-cycle-latency memory for unit B: word = 0xB0000000 + address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_b.imem_rvalid_i <= 1'b0;
      bus_b.imem_rdata_i  <= '0;
    end else begin
      bus_b.imem_rvalid_i <= bus_b.imem_req_o & bus_b.imem_gnt_i;
      bus_b.imem_rdata_i  <= 32'hB000_0000 + bus_b.imem_addr_o;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  f_in;   // pv gnt rv rdy fl
    logic [31:0] pc;
    logic [31:0] rd;
    logic [3:0]  f_exp;  // req prdy vld mis
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic [1:0]  e_dc;
  } vec_t;

  localparam int NV = 35;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [4:0] f_in, input logic [31:0] pc,
                              input logic [31:0] rd, input logic [3:0] f_exp,
                              input logic [31:0] e_instr, input logic [31:0] e_ipc,
                              input logic [1:0] e_dc);
    vec_t v;
    v.f_in = f_in; v.pc = pc; v.rd = rd; v.f_exp = f_exp;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_dc = e_dc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, elapsed %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin
    // backpressure with ready low, then release
    vt[0]  = mk(5'b11000, 'h00, 'h0,         4'b1100, 'h0,         'h00, 2'd0);
    vt[1]  = mk(5'b11100, 'h04, 'hA000_0000, 4'b1100, 'h0,         'h00, 2'd0);
    vt[2]  = mk(5'b11100, 'h08, 'hA000_0004, 4'b0010, 'hA000_0000, 'h00, 2'd0);
    vt[3]  = mk(5'b11000, 'h08, 'h0,         4'b0010, 'hA000_0000, 'h00, 2'd0);
    vt[4]  = mk(5'b11010, 'h08, 'h0,         4'b0010, 'hA000_0000, 'h00, 2'd0);
    vt[5]  = mk(5'b11000, 'h08, 'h0,         4'b1110, 'hA000_0004, 'h04, 2'd0);
    vt[6]  = mk(5'b11110, 'h0C, 'hA000_0008, 4'b0010, 'hA000_0004, 'h04, 2'd0);
    vt[7]  = mk(5'b00010, 'h00, 'h0,         4'b0010, 'hA000_0008, 'h08, 2'd0);
    vt[8]  = mk(5'b00010, 'h00, 'h0,         4'b0000, 'h0,         'h00, 2'd0);
    // grant stall at 0x10
    vt[9]  = mk(5'b10010, 'h10, 'h0,         4'b1000, 'h0,         'h00, 2'd0);
    vt[10] = mk(5'b10010, 'h10, 'h0,         4'b1000, 'h0,         'h00, 2'd0);
    vt[11] = mk(5'b10010, 'h10, 'h0,         4'b1000, 'h0,         'h00, 2'd0);
    vt[12] = mk(5'b11010, 'h10, 'h0,         4'b1100, 'h0,         'h00, 2'd0);
    vt[13] = mk(5'b00110, 'h10, 'hA000_0010, 4'b0000, 'h0,         'h00, 2'd0);
    vt[14] = mk(5'b00010, 'h10, 'h0,         4'b0010, 'hA000_0010, 'h10, 2'd0);
    vt[15] = mk(5'b00010, 'h00, 'h0,         4'b0000, 'h0,         'h00, 2'd0);
    // flush with two outstanding, redirect to 0x40
    vt[16] = mk(5'b11010, 'h20, 'h0,         4'b1100, 'h0,         'h00, 2'd0);
    vt[17] = mk(5'b11010, 'h24, 'h0,         4'b1100, 'h0,         'h00, 2'd0);
    vt[18] = mk(5'b11011, 'h40, 'h0,         4'b0000, 'h0,         'h00, 2'd0);
    vt[19] = mk(5'b11110, 'h40, 'hA000_0020, 4'b1100, 'h0,         'h00, 2'd2);
    vt[20] = mk(5'b00110, 'h40, 'hA000_0024, 4'b0000, 'h0,         'h00, 2'd1);
    vt[21] = mk(5'b00110, 'h40, 'hA000_0040, 4'b0000, 'h0,         'h00, 2'd0);
    vt[22] = mk(5'b00010, 'h00, 'h0,         4'b0010, 'hA000_0040, 'h40, 2'd0);
    vt[23] = mk(5'b00010, 'h00, 'h0,         4'b0000, 'h0,         'h00, 2'd0);
    // flush coinciding with a response
    vt[24] = mk(5'b11010, 'h50, 'h0,         4'b1100, 'h0,         'h00, 2'd0);
    vt[25] = mk(5'b11010, 'h54, 'h0,         4'b1100, 'h0,         'h00, 2'd0);
    vt[26] = mk(5'b11111, 'h58, 'hA000_0050, 4'b0000, 'h0,         'h00, 2'd0);
    vt[27] = mk(5'b00110, 'h58, 'hA000_0054, 4'b0000, 'h0,         'h00, 2'd1);
    vt[28] = mk(5'b00010, 'h00, 'h0,         4'b0000, 'h0,         'h00, 2'd0);
    // misaligned 0x22 behind one outstanding fetch
    vt[29] = mk(5'b11010, 'h30, 'h0,         4'b1100, 'h0,         'h00, 2'd0);
    vt[30] = mk(5'b11010, 'h22, 'h0,         4'b0000, 'h0,         'h00, 2'd0);
    vt[31] = mk(5'b11110, 'h22, 'hA000_0030, 4'b0000, 'h0,         'h00, 2'd0);
    vt[32] = mk(5'b11010, 'h22, 'h0,         4'b0110, 'hA000_0030, 'h30, 2'd0);
    vt[33] = mk(5'b00010, 'h00, 'h0,         4'b0011, 'h0000_0013, 'h22, 2'd0);
    vt[34] = mk(5'b00010, 'h00, 'h0,         4'b0000, 'h0,         'h00, 2'd0);

    rst = 1'b1;
    pv_a = 1'b0; pc_a = '0; flush_a = 1'b0; rdy_a = 1'b0;
    bus_a.imem_gnt_i = 1'b0; bus_a.imem_rvalid_i = 1'b0; bus_a.imem_rdata_i = '0;
    pv_b = 1'b0; pc_b = '0; flush_b = 1'b0; rdy_b = 1'b1; bus_b.imem_gnt_i = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("reset req",    32'(bus_a.imem_req_o), 32'd0);
    chk("reset prdy",   32'(prdy_a), 32'd0);
    chk("reset vld",    32'(vld_a), 32'd0);
    chk("reset instr",  instr_a, 32'd0);
    chk("reset ipc",    ipc_a, 32'd0);
    chk("reset mis",    32'(mis_a), 32'd0);
    chk("reset vld_b",  32'(vld_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      {pv_a, bus_a.imem_gnt_i, bus_a.imem_rvalid_i, rdy_a, flush_a} = vt[i].f_in;
      pc_a = vt[i].pc;
      bus_a.imem_rdata_i = vt[i].rd;
      #1;
      chk($sformatf("v%0d req", i),  32'(bus_a.imem_req_o), 32'(vt[i].f_exp[3]));
      chk($sformatf("v%0d prdy", i), 32'(prdy_a), 32'(vt[i].f_exp[2]));
      chk($sformatf("v%0d vld", i),  32'(vld_a), 32'(vt[i].f_exp[1]));
      chk($sformatf("v%0d dcnt", i), 32'(dut_a.discard_cnt), 32'(vt[i].e_dc));
      if (vt[i].f_exp[3]) chk($sformatf("v%0d addr", i), bus_a.imem_addr_o, vt[i].pc);
      if (vt[i].f_exp[1]) begin
        chk($sformatf("v%0d instr", i), instr_a, vt[i].e_instr);
        chk($sformatf("v%0d ipc", i),   ipc_a, vt[i].e_ipc);
        chk($sformatf("v%0d mis", i),   32'(mis_a), 32'(vt[i].f_exp[0]));
      end
    end

    // streaming on the DEPTH=4 unit: one entry per cycle once the pipe fills
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      pv_b = (k < 4);
      pc_b = (k < 4) ? 32'(4 * k) : 32'd0;
      #1;
      chk($sformatf("s%0d prdy", k), 32'(prdy_b), 32'(k < 4));
      chk($sformatf("s%0d vld", k),  32'(vld_b), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        chk($sformatf("s%0d ipc", k),   ipc_b, 32'(4 * (k - 2)));
        chk($sformatf("s%0d instr", k), instr_b, 32'hB000_0000 + 32'(4 * (k - 2)));
      end
    end
    @(negedge clk);
    pv_b = 1'b0;

    // reset while one word is queued and one request is outstanding
    @(negedge clk);
    pv_a = 1'b1; pc_a = 32'h70; bus_a.imem_gnt_i = 1'b1; rdy_a = 1'b0; flush_a = 1'b0;
    bus_a.imem_rvalid_i = 1'b0;
    @(negedge clk);
    pc_a = 32'h74; bus_a.imem_rvalid_i = 1'b1; bus_a.imem_rdata_i = 32'hA000_0070;
    #1;
    chk("prerst prdy", 32'(prdy_a), 32'd1);
    @(negedge clk);
    bus_a.imem_rvalid_i = 1'b0; bus_a.imem_gnt_i = 1'b0; pc_a = 32'h78;
    #1;
    chk("prerst vld", 32'(vld_a), 32'd1);
    chk("prerst ipc", ipc_a, 32'h70);
    chk("prerst req", 32'(bus_a.imem_req_o), 32'd0);
    pv_a = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst vld", 32'(vld_a), 32'd0);
    chk("midrst ipc", ipc_a, 32'd0);
    chk("midrst req", 32'(bus_a.imem_req_o), 32'd0);
    @(negedge clk);
    rst = 1'b0; pv_a = 1'b1; pc_a = 32'h78;
    #1;
    chk("postrst req", 32'(bus_a.imem_req_o), 32'd1);
    chk("postrst vld", 32'(vld_a), 32'd0);
    @(negedge clk);
    pv_a = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
